// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// Optional macro MDU_DIVZERO_FLAG_EN: divide-by-zero skips iteration and raises divZero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic             hiWrite,
    input  logic             loWrite,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_FLAG_EN
    ,
    output logic             divZero
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;

    logic             sgn_op, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        sgn_op = ~op[0];
        a_neg  = sgn_op & rsData[WIDTH-1];
        b_neg  = sgn_op & rtData[WIDTH-1];
        b_zero = (rtData == '0);
        mag_a  = a_neg ? -rsData : rsData;
        mag_b  = b_neg ? -rtData : rtData;
    end

    // One iteration step; on the final step the sign-fixed result goes straight to HI/LO.
    logic [WIDTH:0]     sum, shifted, diff;
    logic               ge;
    logic [WIDTH-1:0]   nxt_hi, nxt_lo, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sum     = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : '0);
        shifted = {p_hi, p_lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, opb});
        diff    = shifted - {1'b0, opb};
        if (is_div) begin
            nxt_hi = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            nxt_lo = {p_lo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], p_lo[WIDTH-1:1]};
        end
        prod = {nxt_hi, nxt_lo};
        if (neg_q)
            prod = -prod;
        if (is_div) begin
            res_hi = neg_r ? -nxt_hi : nxt_hi;
            res_lo = neg_q ? -nxt_lo : nxt_lo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opb    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
`ifdef MDU_DIVZERO_FLAG_EN
            divZero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        neg_r  <= a_neg;
                        // A zero signed divisor counts as negative, so x/0 fixes up to +1 for x >= 0.
                        neg_q  <= a_neg ^ b_neg ^ (sgn_op & op[1] & b_zero);
                        opb    <= op[1] ? mag_b : mag_a;
                        p_lo   <= op[1] ? mag_a : mag_b;
                        p_hi   <= '0;
                        cnt    <= '0;
`ifdef MDU_DIVZERO_FLAG_EN
                        divZero <= 1'b0;
                        if (op[1] && b_zero) begin
                            state   <= FIX;
                            done    <= 1'b1;
                            divZero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`else
                        state <= RUN;
                        busy  <= 1'b1;
`endif
                    end else begin
                        if (hiWrite)
                            hi <= rsData;
                        if (loWrite)
                            lo <= rsData;
                    end
                end
                RUN: begin
                    p_hi <= nxt_hi;
                    p_lo <= nxt_lo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= res_hi;
                        lo    <= res_lo;
                    end
                end
                FIX:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multicycle multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file and consumes the $rs/$rt read data (outputData1/outputData2).
- Executes MULT, MULTU, DIV and DIVU iteratively and holds the results in the HI/LO registers.
- HI/LO are read back for MFHI/MFLO and enter the register file's writeData mux. MTHI/MTLO write them directly.

Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin the operation selected by op.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rsData  in  WIDTH  $rs operand (multiplicand/dividend), from regfile outputData1.
- rtData  in  WIDTH  $rt operand (multiplier/divisor), from regfile outputData2.
- hiWrite  in  1  MTHI: HI <= rsData.
- loWrite  in  1  MTLO: LO <= rsData.
- busy  out  1  operation in progress; the control FSM stalls MFHI/MFLO while high.
- done  out  1  one-cycle pulse when HI/LO have been updated by an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- divZero  out  1  (only with MDU_DIVZERO_FLAG_EN) divide-by-zero flag.

Behaviour:
- Reset (sync, any state, including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, divZero=0, iteration counter=0. The operation in flight is discarded.
- FSM states:
  - IDLE: start=1 latches op, latches rsData/rtData and goes to RUN. Signed ops latch absolute values and record the signs.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Exactly WIDTH cycles, counter 0..WIDTH-1, then FIX.
  - FIX: apply sign correction, write HI/LO, done=1 for this cycle only, go to IDLE.
- Latency: start sampled at edge N; busy=1 from edge N+1 through the end of RUN. HI/LO are updated and done pulses at edge N+WIDTH+1 (33 cycles for WIDTH=32). busy=0 in the done cycle.
- busy is high in RUN; low in IDLE and FIX.
- Multiply: 2*WIDTH-bit product; HI = upper half, LO = lower half.
  - MULT: product negated (two's complement, 64-bit) when the operand signs differ.
- Divide: LO = quotient, HI = remainder.
  - DIV: quotient negated when the operand signs differ; remainder takes the sign of the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0, no exception.
- start while busy=1 or in FIX: ignored, with no effect on the running operation.
- hiWrite/loWrite:
  - Honoured only in IDLE when start=0.
  - Ignored while busy, in FIX, or in a cycle where start is accepted.
  - hiWrite and loWrite together: both written from rsData.
- hi/lo hold their value between updates. Intermediate accumulator state is never visible on hi/lo before FIX.

Optional Feature:
- Macro: MDU_DIVZERO_FLAG_EN.
- Defined:
  - DIV/DIVU with rtData=0 skips RUN and goes IDLE->FIX, so done pulses at edge N+1.
  - HI/LO are left unchanged. divZero=1 in the done cycle and stays 1 until the next accepted start or reset.
  - The divZero port exists.
- Undefined:
  - No divZero port; division by zero runs the full WIDTH iterations.
  - DIVU x/0: LO=0xFFFFFFFF, HI=x.
  - DIV: the restoring result on the magnitudes, then normal sign fixup. Example: DIV 7/0 gives LO=0x00000001, HI=7.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0x00000002, start at cycle 0 -> busy 1 for cycles 1..32; done at cycle 33; HI=0x00000001, LO=0xFFFFFFFE.
- MULT rs=-3 (0xFFFFFFFD), rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU rs=100, rt=7 -> LO=14, HI=2. DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 by -1 -> LO=0x80000000, HI=0.
- During a busy MULTU, pulse start with op=DIV and assert hiWrite with rsData=0x1234 -> both ignored; the original MULTU result is written, done pulses once.
- MTHI 0xAAAA5555, then MTLO 0x0F0F0F0F in IDLE -> hi/lo show them the next cycle. Reset asserted at RUN cycle 10 -> next cycle hi=lo=0, busy=0, no done pulse.
- DIVU rs=9, rt=0:
  - With MDU_DIVZERO_FLAG_EN: done at cycle 1, divZero=1, HI/LO unchanged.
  - Without the macro: done at cycle 33, LO=0xFFFFFFFF, HI=9.
